// File: rtl/fbuff_pattern_pkg.sv
// Shared types and helpers for the frame-buffer pattern initialiser.
// Holds the pattern/FSM enums and the colour-level replication function.
package fbuff_pattern_pkg;

   localparam int LVL_MAX_W  = 64;
   localparam int LVL_MAX_CH = 16;

   typedef enum logic [1:0] {
      PAT_COUNTER = 2'd0,
      PAT_SOLID   = 2'd1,
      PAT_HGRAD   = 2'd2,
      PAT_CHECKER = 2'd3
   } pattern_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } fsm_state_t;

   // Low 'depth' bits of v copied into each of 'channels' channel slots; callers size-cast the result.
   function automatic logic [LVL_MAX_W-1:0] replicate_lvl(input logic [31:0] v,
                                                          input int depth,
                                                          input int channels);
      logic [LVL_MAX_W-1:0] mask;
      logic [LVL_MAX_W-1:0] res;
      mask = (LVL_MAX_W'(1) << depth) - LVL_MAX_W'(1);
      res  = '0;
      for (int c = 0; c < LVL_MAX_CH; c++) begin
         if (c < channels) begin
            res = res | ((LVL_MAX_W'(v) & mask) << (c * depth));
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/fbuff_pattern_row.sv
// Combinational builder for one frame-buffer row of tiles.
// Tile 0 sits in the LSBs; x = r*TILE_PER_ROW + k for tile k.
module fbuff_pattern_row
   import fbuff_pattern_pkg::*;
#(
   parameter int PXL_WIDTH    = 12,
   parameter int DEPTH_COLR   = 4,
   parameter int TILE_PER_ROW = 5,
   parameter int ADDR_WIDTH   = 12,
   parameter int R_WIDTH      = 6,
   parameter int Y_WIDTH      = 7,
   parameter int DATA_WIDTH   = TILE_PER_ROW * PXL_WIDTH
) (
   input  logic [1:0]            mode_i,
   input  logic [PXL_WIDTH-1:0]  colour_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [R_WIDTH-1:0]    r_i,
   input  logic [Y_WIDTH-1:0]    y_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   localparam int CHANNELS = PXL_WIDTH / DEPTH_COLR;

   generate
      for (genvar gi = 0; gi < TILE_PER_ROW; gi++) begin : g_tile
         logic [31:0]          w_x;
         logic                 w_par;
         logic [PXL_WIDTH-1:0] w_tile;

         assign w_x   = 32'(r_i) * 32'(TILE_PER_ROW) + 32'(gi);
         // LSB of x+y equals x[0]^y[0]
         assign w_par = 1'(w_x + 32'(y_i));

         always_comb begin
            w_tile = colour_i;
            case (pattern_mode_t'(mode_i))
               PAT_COUNTER: w_tile = PXL_WIDTH'(replicate_lvl(32'(addr_i), DEPTH_COLR, CHANNELS));
               PAT_SOLID:   w_tile = colour_i;
               PAT_HGRAD:   w_tile = PXL_WIDTH'(replicate_lvl(w_x, DEPTH_COLR, CHANNELS));
               PAT_CHECKER: w_tile = w_par ? ~colour_i : colour_i;
               default:     w_tile = colour_i;
            endcase
         end

         assign data_o[gi*PXL_WIDTH +: PXL_WIDTH] = w_tile;
      end
   endgenerate

endmodule

// File: rtl/fbuff_pattern_gen.sv
// Frame-buffer initialiser: on start, writes one pattern row per clock into every RAM row.
// Supports hold (pause), abort (cancel) and a one-cycle done pulse; all outputs registered.
module fbuff_pattern_gen
   import fbuff_pattern_pkg::*;
#(
   parameter int PXL_WIDTH        = 12,
   parameter int DEPTH_COLR       = 4,
   parameter int TILE_PER_ROW     = 5,
   parameter int TILE_PER_LINE    = 160,
   parameter int TILE_LINES       = 120,
   parameter int FBUFF_DEPTH      = TILE_PER_LINE * TILE_LINES / TILE_PER_ROW,
   parameter int FBUFF_ADDR_WIDTH = $clog2(FBUFF_DEPTH),
   parameter int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        start_i,
   input  logic [1:0]                  mode_i,
   input  logic [PXL_WIDTH-1:0]        colour_i,
   input  logic                        hold_i,
   input  logic                        abort_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
   output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
   output logic                        fbuff_en_o,
   output logic                        fbuff_wen_o
);

   localparam int ROWS_PER_LINE = TILE_PER_LINE / TILE_PER_ROW;
   localparam int R_WIDTH       = $clog2(ROWS_PER_LINE + 1);
   localparam int Y_WIDTH       = $clog2(TILE_LINES + 1);
   localparam logic [R_WIDTH-1:0]          R_LAST   = R_WIDTH'(ROWS_PER_LINE - 1);
   localparam logic [FBUFF_ADDR_WIDTH-1:0] ROW_LAST = FBUFF_ADDR_WIDTH'(FBUFF_DEPTH - 1);

   fsm_state_t                  r_state;
   pattern_mode_t               r_mode;
   logic [PXL_WIDTH-1:0]        r_colour;
   logic [FBUFF_ADDR_WIDTH-1:0] r_row_cnt;
   logic [R_WIDTH-1:0]          r_r;
   logic [Y_WIDTH-1:0]          r_y;
   logic [FBUFF_ADDR_WIDTH-1:0] r_addr;
   logic [FBUFF_DATA_WIDTH-1:0] r_data;
   logic                        r_en;
   logic                        r_wen;
   logic                        r_busy;
   logic                        r_done;
   logic [FBUFF_DATA_WIDTH-1:0] w_row_data;

   fbuff_pattern_row #(
      .PXL_WIDTH    (PXL_WIDTH),
      .DEPTH_COLR   (DEPTH_COLR),
      .TILE_PER_ROW (TILE_PER_ROW),
      .ADDR_WIDTH   (FBUFF_ADDR_WIDTH),
      .R_WIDTH      (R_WIDTH),
      .Y_WIDTH      (Y_WIDTH),
      .DATA_WIDTH   (FBUFF_DATA_WIDTH)
   ) u_row (
      .mode_i   (r_mode),
      .colour_i (r_colour),
      .addr_i   (r_row_cnt),
      .r_i      (r_r),
      .y_i      (r_y),
      .data_o   (w_row_data)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state   <= IDLE;
         r_mode    <= PAT_COUNTER;
         r_colour  <= '0;
         r_row_cnt <= '0;
         r_r       <= '0;
         r_y       <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         r_en      <= 1'b0;
         r_wen     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_en  <= 1'b0;
               r_wen <= 1'b0;
               if (start_i) begin
                  r_state   <= LOAD;
                  r_mode    <= pattern_mode_t'(mode_i);
                  r_colour  <= colour_i;
                  r_row_cnt <= '0;
                  r_r       <= '0;
                  r_y       <= '0;
                  r_busy    <= 1'b1;
               end
            end
            LOAD: begin
               if (abort_i) begin
                  r_en    <= 1'b0;
                  r_wen   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (hold_i) begin
                  r_en  <= 1'b0;
                  r_wen <= 1'b0;
               end else begin
                  r_en      <= 1'b1;
                  r_wen     <= 1'b1;
                  r_addr    <= r_row_cnt;
                  r_data    <= w_row_data;
                  r_row_cnt <= r_row_cnt + FBUFF_ADDR_WIDTH'(1);
                  // r walks across the line; y advances when r wraps
                  if (r_r == R_LAST) begin
                     r_r <= '0;
                     r_y <= r_y + Y_WIDTH'(1);
                  end else begin
                     r_r <= r_r + R_WIDTH'(1);
                  end
                  if (r_row_cnt == ROW_LAST) begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_en    <= 1'b0;
               r_wen   <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= !abort_i;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign fbuff_addr_o = r_addr;
   assign fbuff_data_o = r_data;
   assign fbuff_en_o   = r_en;
   assign fbuff_wen_o  = r_wen;

endmodule

// File: tb/tb_fbuff_pattern_gen.sv
// Directed self-checking bench for fbuff_pattern_gen with hand-computed row values.
// Covers reset, all four patterns, hold, abort, start-while-busy and mid-fill reset.
module tb_fbuff_pattern_gen;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        start_i;
   logic [1:0]  mode_i;
   logic [11:0] colour_i;
   logic        hold_i;
   logic        abort_i;
   logic        busy_o;
   logic        done_o;
   logic [11:0] fbuff_addr_o;
   logic [59:0] fbuff_data_o;
   logic        fbuff_en_o;
   logic        fbuff_wen_o;

   int n_checks = 0;
   int n_fail   = 0;

   int wr_cnt, first_wr, last_wr, first_addr, last_addr;
   int done_cnt, done_cyc, seq_err, pat_err;
   int hold_wr_cyc, resume_wr_cyc, abort_cyc;
   logic abort_wen, abort_busy, busy_end;
   logic [59:0] busy_start_data;
   logic [59:0] cap [0:63];

   fbuff_pattern_gen dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .start_i      (start_i),
      .mode_i       (mode_i),
      .colour_i     (colour_i),
      .hold_i       (hold_i),
      .abort_i      (abort_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .fbuff_addr_o (fbuff_addr_o),
      .fbuff_data_o (fbuff_data_o),
      .fbuff_en_o   (fbuff_en_o),
      .fbuff_wen_o  (fbuff_wen_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [59:0] exp_counter(input int a);
      logic [3:0] n;
      n = a[3:0];
      return {15{n}};
   endfunction

   // Run one fill from start; reacts to observed write addresses to inject hold/abort/start.
   task automatic run_fill(input logic [1:0] mode, input logic [11:0] colour,
                           input int hold_at, input int abort_at, input int busy_start_at);
      int   hold_left;
      int   post_done;
      logic stop;
      int   a;
      wr_cnt = 0; first_wr = -1; last_wr = -1; first_addr = -1; last_addr = -1;
      done_cnt = 0; done_cyc = -1; seq_err = 0; pat_err = 0;
      hold_wr_cyc = -1; resume_wr_cyc = -1; abort_cyc = -1;
      abort_wen = 1'b1; abort_busy = 1'b1; busy_end = 1'b1; busy_start_data = '0;
      for (int i = 0; i < 64; i++) cap[i] = '1;
      mode_i = mode; colour_i = colour; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check_val("busy_after_start", 64'(busy_o), 64'd1);
      check_val("wen_after_start", 64'(fbuff_wen_o), 64'd0);
      hold_left = 0; post_done = 0; stop = 1'b0;
      for (int c = 1; c <= 4000 && !stop; c++) begin
         step();
         start_i = 1'b0;
         abort_i = 1'b0;
         if (fbuff_wen_o) begin
            a = int'(fbuff_addr_o);
            if (first_wr < 0) begin
               first_wr   = c;
               first_addr = a;
            end
            last_wr = c;
            wr_cnt++;
            if (a != last_addr + 1 || fbuff_en_o !== 1'b1) seq_err++;
            last_addr = a;
            if (a < 64) cap[a] = fbuff_data_o;
            if (mode == 2'd0 && fbuff_data_o !== exp_counter(a)) pat_err++;
            if (hold_at >= 0 && a == hold_at + 1) resume_wr_cyc = c;
            if (a == hold_at) begin
               hold_wr_cyc = c;
               hold_left   = 10;
            end
            if (a == abort_at) begin
               abort_cyc = c;
               abort_i   = 1'b1;
            end
            if (a == busy_start_at) begin
               start_i  = 1'b1;
               mode_i   = 2'd1;
               colour_i = 12'hABC;
            end
            if (busy_start_at >= 0 && a == busy_start_at + 1) busy_start_data = fbuff_data_o;
         end
         if (abort_cyc >= 0 && c == abort_cyc + 1) begin
            abort_wen  = fbuff_wen_o;
            abort_busy = busy_o;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = c;
         end
         if (hold_left > 0) begin
            hold_i = 1'b1;
            hold_left--;
         end else begin
            hold_i = 1'b0;
         end
         if (abort_i) hold_i = 1'b1;
         if (done_cnt > 0) post_done++;
         if (post_done == 3 || (abort_cyc >= 0 && c >= abort_cyc + 20)) stop = 1'b1;
      end
      busy_end = busy_o;
      hold_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
   endtask

   initial begin
      int   found;
      int   post_done_cnt, post_busy, post_wen;
      rstn_i = 1'b0; start_i = 1'b0; mode_i = 2'd0; colour_i = 12'h000;
      hold_i = 1'b0; abort_i = 1'b0;

      // Reset state
      repeat (3) step();
      check_val("rst_busy", 64'(busy_o), 64'd0);
      check_val("rst_done", 64'(done_o), 64'd0);
      check_val("rst_en", 64'(fbuff_en_o), 64'd0);
      check_val("rst_wen", 64'(fbuff_wen_o), 64'd0);
      check_val("rst_addr", 64'(fbuff_addr_o), 64'd0);
      check_val("rst_data", 64'(fbuff_data_o), 64'd0);
      rstn_i = 1'b1;
      step();

      // COUNTER fill with an ignored start at addr 300
      run_fill(2'd0, 12'h000, -1, -1, 300);
      check_val("cnt_first_wr_cyc", 64'(first_wr), 64'd1);
      check_val("cnt_first_addr", 64'(first_addr), 64'd0);
      check_val("cnt_last_wr_cyc", 64'(last_wr), 64'd3840);
      check_val("cnt_wr_count", 64'(wr_cnt), 64'd3840);
      check_val("cnt_last_addr", 64'(last_addr), 64'd3839);
      check_val("cnt_seq_err", 64'(seq_err), 64'd0);
      check_val("cnt_pat_err", 64'(pat_err), 64'd0);
      check_val("cnt_addr17", 64'(cap[17]), 64'(60'h111111111111111));
      check_val("cnt_addr16", 64'(cap[16]), 64'd0);
      check_val("cnt_busy_start_ignored", 64'(busy_start_data), 64'(60'hDDDDDDDDDDDDDDD));
      check_val("cnt_done_count", 64'(done_cnt), 64'd1);
      check_val("cnt_done_cyc", 64'(done_cyc), 64'd3841);
      check_val("cnt_busy_end", 64'(busy_end), 64'd0);

      // HGRAD fill
      run_fill(2'd2, 12'h000, -1, -1, -1);
      check_val("hg_a1_t0", 64'(cap[1][11:0]), 64'h555);
      check_val("hg_a1_t4", 64'(cap[1][59:48]), 64'h999);
      check_val("hg_a1_row", 64'(cap[1]), 64'(60'h999888777666555));
      check_val("hg_a3_t0", 64'(cap[3][11:0]), 64'hFFF);
      check_val("hg_a3_t1", 64'(cap[3][23:12]), 64'h000);
      check_val("hg_a3_row", 64'(cap[3]), 64'(60'h333222111000FFF));
      check_val("hg_done_cyc", 64'(done_cyc), 64'd3841);

      // CHECKER fill aborted at addr 200 (hold raised with abort)
      run_fill(2'd3, 12'hF00, -1, 200, -1);
      check_val("ck_a0_t0", 64'(cap[0][11:0]), 64'hF00);
      check_val("ck_a0_t1", 64'(cap[0][23:12]), 64'h0FF);
      check_val("ck_a0_row", 64'(cap[0]), 64'(60'hF000FFF000FFF00));
      check_val("ck_a1_row", 64'(cap[1]), 64'(60'h0FFF000FFF000FF));
      check_val("ck_a32_t0", 64'(cap[32][11:0]), 64'h0FF);
      check_val("ck_a32_row", 64'(cap[32]), 64'(60'h0FFF000FFF000FF));
      check_val("ab_wen_next", 64'(abort_wen), 64'd0);
      check_val("ab_busy_next", 64'(abort_busy), 64'd0);
      check_val("ab_no_done", 64'(done_cnt), 64'd0);
      check_val("ab_last_addr", 64'(last_addr), 64'd200);

      // Restart after abort, with a 10-cycle hold at addr 50
      run_fill(2'd0, 12'h000, 50, -1, -1);
      check_val("rs_first_addr", 64'(first_addr), 64'd0);
      check_val("hd_gap", 64'(resume_wr_cyc - hold_wr_cyc - 1), 64'd10);
      check_val("hd_seq_err", 64'(seq_err), 64'd0);
      check_val("hd_pat_err", 64'(pat_err), 64'd0);
      check_val("hd_wr_count", 64'(wr_cnt), 64'd3840);
      check_val("hd_done_cyc", 64'(done_cyc), 64'd3851);

      // IDLE abort has no effect; start+abort together starts; abort in LOAD cancels
      abort_i = 1'b1;
      step();
      check_val("idle_abort_busy", 64'(busy_o), 64'd0);
      start_i = 1'b1; mode_i = 2'd1; colour_i = 12'h123;
      step();
      start_i = 1'b0;
      check_val("start_abort_busy", 64'(busy_o), 64'd1);
      step();
      check_val("load_abort_busy", 64'(busy_o), 64'd0);
      check_val("load_abort_wen", 64'(fbuff_wen_o), 64'd0);
      abort_i = 1'b0;
      step();
      check_val("load_abort_done", 64'(done_o), 64'd0);

      // Reset mid-fill at row 100
      mode_i = 2'd0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      found = 0;
      for (int c = 0; c < 300 && found == 0; c++) begin
         step();
         if (fbuff_wen_o && fbuff_addr_o == 12'd100) found = 1;
      end
      check_val("mr_reach_row100", 64'(found), 64'd1);
      #2 rstn_i = 1'b0;
      #1;
      check_val("mr_busy", 64'(busy_o), 64'd0);
      check_val("mr_en_wen", 64'({fbuff_en_o, fbuff_wen_o}), 64'd0);
      check_val("mr_addr", 64'(fbuff_addr_o), 64'd0);
      check_val("mr_data", 64'(fbuff_data_o), 64'd0);
      step();
      step();
      rstn_i = 1'b1;
      post_done_cnt = 0; post_busy = 0; post_wen = 0;
      for (int c = 0; c < 50; c++) begin
         step();
         if (done_o) post_done_cnt++;
         if (busy_o) post_busy++;
         if (fbuff_wen_o) post_wen++;
      end
      check_val("mr_post_done", 64'(post_done_cnt), 64'd0);
      check_val("mr_post_busy", 64'(post_busy), 64'd0);
      check_val("mr_post_wen", 64'(post_wen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
